// File: rtl/cpu_isa_pkg.sv
// Shared 16-bit instruction set definitions used by the loader (encode) and the CPU (decode).
package cpu_isa_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned REG_W   = 3;

   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RD_MSB  = 11;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS1_MSB = 8;
   localparam int unsigned RS1_LSB = 6;
   localparam int unsigned RS2_MSB = 5;
   localparam int unsigned RS2_LSB = 3;

   localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD     = 4'b0001;
   localparam logic [OP_W-1:0] OP_SUB     = 4'b0010;
   localparam logic [OP_W-1:0] OP_AND     = 4'b0011;
   localparam logic [OP_W-1:0] OP_OR      = 4'b0100;
   localparam logic [OP_W-1:0] OP_XOR     = 4'b0101;
   localparam logic [OP_W-1:0] OP_NOWRITE = 4'b1001;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } instr_fields_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } ld_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded fields -> 16-bit instruction word.
// Opcodes without write-back carry a zero rd field.
module instr_field_pack
   import cpu_isa_pkg::*;
#(
   parameter logic [OP_W-1:0] NOWRITE_OP = OP_NOWRITE
) (
   input  instr_fields_t      fields,
   output logic [INSTR_W-1:0] word_c
);

   always_comb begin
      word_c                   = '0;
      word_c[OP_MSB:OP_LSB]    = fields.op;
      word_c[RD_MSB:RD_LSB]    = (fields.op == NOWRITE_OP) ? REG_W'(0) : fields.rd;
      word_c[RS1_MSB:RS1_LSB]  = fields.rs1;
      word_c[RS2_MSB:RS2_LSB]  = fields.rs2;
   end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts decoded field beats, encodes them and writes
// instruction memory sequentially. Optional running XOR checksum: INSTR_LOADER_CKSUM_EN.
module instr_loader
   import cpu_isa_pkg::*;
#(
   parameter int unsigned     ADDR_W     = 8,
   parameter logic [OP_W-1:0] NOWRITE_OP = OP_NOWRITE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       in_opcode,
   input  logic [REG_W-1:0]      in_rd,
   input  logic [REG_W-1:0]      in_rs1,
   input  logic [REG_W-1:0]      in_rs2,
   input  logic                  in_last,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [INSTR_W-1:0]    mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W:0]       instr_count
`ifdef INSTR_LOADER_CKSUM_EN
   ,
   output logic [INSTR_W-1:0]    cksum
`endif
);

   localparam int unsigned       CNT_W    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   ld_state_e            state_q, state_d;
   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d;
   logic                 mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [INSTR_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                 cpu_hold_q, cpu_hold_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
`ifdef INSTR_LOADER_CKSUM_EN
   logic [INSTR_W-1:0]   cksum_q, cksum_d;
`endif

   instr_fields_t        fields_c;
   logic [INSTR_W-1:0]   word_c;
   logic                 accept_c;

   assign fields_c = '{op: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
   assign accept_c = in_valid & in_ready_q;

   instr_field_pack #(
      .NOWRITE_OP (NOWRITE_OP)
   ) u_pack (
      .fields (fields_c),
      .word_c (word_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      done_d      = done_q;
      err_d       = err_q;
`ifdef INSTR_LOADER_CKSUM_EN
      cksum_d     = cksum_q;
`endif

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = LOAD;
               ptr_d      = '0;
               cnt_d      = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               in_ready_d = 1'b1;
               cpu_hold_d = 1'b1;
`ifdef INSTR_LOADER_CKSUM_EN
               cksum_d    = '0;
`endif
            end
         end
         LOAD: begin
            if (accept_c) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_q;
               mem_wdata_d = word_c;
               ptr_d       = ptr_q + ADDR_W'(1);
               cnt_d       = cnt_q + CNT_W'(1);
`ifdef INSTR_LOADER_CKSUM_EN
               cksum_d     = cksum_q ^ word_c;
`endif
               if (in_last) begin
                  state_d    = DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
                  in_ready_d = 1'b0;
               end else if (ptr_q == PTR_LAST) begin
                  // Last slot filled without end of program: stop and keep CPU held.
                  state_d    = ERR;
                  err_d      = 1'b1;
                  in_ready_d = 1'b0;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef INSTR_LOADER_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef INSTR_LOADER_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   assign in_ready    = in_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_hold    = cpu_hold_q;
   assign done        = done_q;
   assign err         = err_q;
   assign instr_count = cnt_q;
`ifdef INSTR_LOADER_CKSUM_EN
   assign cksum       = cksum_q;
`endif

endmodule
